// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider; done pulses DATA_W+2 edges after start, no backpressure (start ignored while running).
// Define MULDIV_DIVIDE_EN to build the divider; without it op=1 completes with hi=lo=0, err=1.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              op,
  input  logic              sgn,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              err
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   rq_q, rq_d;
  logic [DATA_W-1:0]   md_q, md_d;
  logic                op_q, op_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                err_q, err_d;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod, prod_fix;
`ifdef MULDIV_DIVIDE_EN
  logic [DATA_W:0]     rem_sh, div_diff;
`endif

  always_comb begin
    a_neg    = sgn & a[DATA_W-1];
    b_neg    = sgn & b[DATA_W-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    // acc holds the running upper half, rq shifts out multiplier bits and in product bits
    mul_sum  = {1'b0, acc_q} + (rq_q[0] ? {1'b0, md_q} : '0);
    prod     = {acc_q, rq_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
`ifdef MULDIV_DIVIDE_EN
    // acc is the partial remainder, rq shifts dividend bits out and quotient bits in
    rem_sh   = {acc_q, rq_q[DATA_W-1]};
    div_diff = rem_sh - {1'b0, md_q};
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rq_d    = rq_q;
    md_d    = md_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          acc_d   = '0;
          rq_d    = a_mag;
          md_d    = b_mag;
          op_d    = op;
          neg_a_d = a_neg;
          neg_b_d = b_neg;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIVIDE_EN
        if (op_q) begin
          acc_d = div_diff[DATA_W] ? rem_sh[DATA_W-1:0] : div_diff[DATA_W-1:0];
          rq_d  = {rq_q[DATA_W-2:0], ~div_diff[DATA_W]};
        end else
`endif
        begin
          acc_d = mul_sum[DATA_W:1];
          rq_d  = {mul_sum[0], rq_q[DATA_W-1:1]};
        end
        if (cnt_q == CW'(DATA_W-1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (op_q) begin
`ifdef MULDIV_DIVIDE_EN
          // with a zero divisor the remainder path has shifted the whole dividend back in
          lo_d  = (md_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -rq_q : rq_q);
          hi_d  = neg_a_q ? -acc_q : acc_q;
          err_d = (md_q == '0);
`else
          hi_d  = '0;
          lo_d  = '0;
          err_d = 1'b1;
`endif
        end else begin
          {hi_d, lo_d} = prod_fix;
          err_d        = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rq_q    <= '0;
      md_q    <= '0;
      op_q    <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rq_q    <= rq_d;
      md_q    <= md_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign err  = err_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus literal checks per operation.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, err;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_W(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .err(err)
  );

  typedef struct packed {
    logic         err;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  function automatic res_t model(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t            r;
    longint          p;
    longint unsigned up;
    int              sx, sy;
    r = '0;
    if (!o) begin
      if (s) begin
        p = longint'($signed(x)) * longint'($signed(y));
        {r.hi, r.lo} = p;
      end else begin
        up = {32'b0, x} * {32'b0, y};
        {r.hi, r.lo} = up;
      end
    end else begin
`ifdef MULDIV_DIVIDE_EN
      if (y == '0) begin
        r.err = 1'b1; r.lo = '1; r.hi = x;
      end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        r.lo = x; r.hi = '0;
      end else if (s) begin
        sx = $signed(x); sy = $signed(y);
        r.lo = 32'(sx / sy);
        r.hi = 32'(sx % sy);
      end else begin
        r.lo = x / y;
        r.hi = x % y;
      end
`else
      r.err = 1'b1;
`endif
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference timeline: an accepted start at edge s gives busy for 33 cycles, done in the next, IDLE after.
  int   cyc = 0;
  int   s_cyc = 0;
  bit   active = 1'b0;
  res_t pend = '0;
  res_t expr = '0;

  always @(posedge clk) begin
    cyc++;
    if (!clr) active = 1'b0;
    else if (active && (cyc - s_cyc) >= 35) active = 1'b0;
    if (clr && !active && start) begin
      active = 1'b1;
      s_cyc  = cyc;
      pend   = model(op, sgn, a, b);
    end
  end

  always @(negedge clk) begin : cmp
    int k;
    bit eb, ed;
    if (!clr) begin
      expr = '0;
      eb = 1'b0;
      ed = 1'b0;
    end else begin
      k  = cyc - s_cyc;
      eb = active && (k <= 32);
      ed = active && (k == 33);
      if (ed) expr = pend;
    end
    chk("cmp.busy", 64'(busy), 64'(eb));
    chk("cmp.done", 64'(done), 64'(ed));
    chk("cmp.hi",   64'(hi),   64'(expr.hi));
    chk("cmp.lo",   64'(lo),   64'(expr.lo));
    chk("cmp.err",  64'(err),  64'(expr.err));
  end

  task automatic run_op(input string nm, input logic o, input logic s,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ee);
    int n, nb;
    @(negedge clk); #1;
    start = 1'b1; op = o; sgn = s; a = x; b = y;
    @(posedge clk); #1;
    n  = 1;
    nb = busy ? 1 : 0;
    @(negedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = ~o; sgn = ~s;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
    end
    if (!done) begin
      chk({nm, ".timeout"}, 64'(done), 64'd1);
      return;
    end
    chk({nm, ".latency"}, 64'(n), 64'd34);
    chk({nm, ".busy_cycles"}, 64'(nb), 64'd33);
    chk({nm, ".hi"}, 64'(hi), 64'(eh));
    chk({nm, ".lo"}, 64'(lo), 64'(el));
    chk({nm, ".err"}, 64'(err), 64'(ee));
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hi",   64'(hi),   64'd0);
    chk("reset.lo",   64'(lo),   64'd0);
    chk("reset.err",  64'(err),  64'd0);
    @(negedge clk); #1;
    clr = 1'b1;

    run_op("umul_max", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("smul_m3x7", 0, 1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("smul_minsq", 0, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
    run_op("umul_min2", 0, 0, 32'h8000_0000, 32'd2, 32'h1, 32'h0, 0);
`ifdef MULDIV_DIVIDE_EN
    run_op("sdiv_m7d2", 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("sdiv_ovf", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
    run_op("udiv_5d0", 1, 0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
    run_op("umul_2x3", 0, 0, 32'd2, 32'd3, 32'd0, 32'd6, 0);
    run_op("sdiv_m5d0", 1, 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
    run_op("sdiv_7dm2", 1, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
    run_op("udiv_9d3", 1, 0, 32'd9, 32'd3, 32'd0, 32'd3, 0);
    run_op("udiv_100d7", 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
`else
    run_op("sdiv_m7d2", 1, 1, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1);
    run_op("udiv_5d0", 1, 0, 32'd5, 32'd0, 32'h0, 32'h0, 1);
    run_op("umul_2x3", 0, 0, 32'd2, 32'd3, 32'd0, 32'd6, 0);
    run_op("udiv_9d3", 1, 0, 32'd9, 32'd3, 32'h0, 32'h0, 1);
    run_op("umul_100x7", 0, 0, 32'd100, 32'd7, 32'd0, 32'd700, 0);
`endif

    // abandon an operation: extra start while busy, then asynchronous reset mid-cycle
    @(negedge clk); #1;
    start = 1'b1; op = 1'b0; sgn = 1'b0; a = 32'd12345; b = 32'd678;
    @(posedge clk);
    @(negedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("abort.busy_before", 64'(busy), 64'd1);
    #1;
    clr = 1'b0;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.hi",   64'(hi),   64'd0);
    chk("abort.lo",   64'(lo),   64'd0);
    chk("abort.err",  64'(err),  64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    clr = 1'b1;
    run_op("restart", 0, 0, 32'd12345, 32'd678, 32'd0, 32'h007F_B6F6, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
